// File: rtl/ecg_pkg.sv
// Shared types and constants for the ECG beat detector.
package ecg_pkg;

    localparam int SAMPLE_W   = 8;
    localparam int INTERVAL_W = 12;
    localparam int SUM_W      = 14;
    localparam int HIST_DEPTH = 4;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SLOW   = 2'd1,
        NORMAL = 2'd2,
        FAST   = 2'd3
    } rate_class_t;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        PEAK    = 2'd1,
        REFRACT = 2'd2
    } beat_state_t;

    // Boundary values fall into NORMAL: only strictly slower/faster averages classify.
    function automatic rate_class_t classify_rate(
        input logic [INTERVAL_W-1:0] avg,
        input logic [INTERVAL_W-1:0] slow_ms,
        input logic [INTERVAL_W-1:0] fast_ms
    );
        if (avg > slow_ms) begin
            return SLOW;
        end
        if (avg < fast_ms) begin
            return FAST;
        end
        return NORMAL;
    endfunction

endpackage

// File: rtl/ecg_beat_detector_ms_tick_gen.sv
// Free-running divider producing a one-cycle pulse every TICK_DIV clocks.
module ms_tick_gen #(
    parameter int TICK_DIV = 27000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // Count 0..TICK_DIV-1 and register a pulse on wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/ecg_beat_detector.sv
// R-peak detector with hysteresis and refractory window, beat-to-beat
// interval measurement, 4-beat running average and heart-rate class.
module ecg_beat_detector
    import ecg_pkg::*;
#(
    parameter int TICK_DIV     = 27000,
    parameter int THRESH_HI    = 200,
    parameter int THRESH_LO    = 160,
    parameter int REFRACT_MS   = 250,
    parameter int MAX_INTERVAL = 2000,
    parameter int SLOW_MS      = 1000,
    parameter int FAST_MS      = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [SAMPLE_W-1:0]   ecg_sample,
    output logic                  beat,
    output logic                  interval_valid,
    output logic [INTERVAL_W-1:0] interval_ms,
    output logic [INTERVAL_W-1:0] avg_interval,
    output logic                  no_signal,
    output logic [1:0]            rate_class
);

    localparam logic [SAMPLE_W-1:0]   HI_C      = SAMPLE_W'(THRESH_HI);
    localparam logic [SAMPLE_W-1:0]   LO_C      = SAMPLE_W'(THRESH_LO);
    localparam logic [INTERVAL_W-1:0] REFRACT_C = INTERVAL_W'(REFRACT_MS);
    localparam logic [INTERVAL_W-1:0] MAX_C     = INTERVAL_W'(MAX_INTERVAL);
    localparam logic [INTERVAL_W-1:0] MAX_M1_C  = INTERVAL_W'(MAX_INTERVAL - 1);
    localparam logic [INTERVAL_W-1:0] SLOW_C    = INTERVAL_W'(SLOW_MS);
    localparam logic [INTERVAL_W-1:0] FAST_C    = INTERVAL_W'(FAST_MS);

    logic                  tick;
    beat_state_t           state;
    logic [INTERVAL_W-1:0] refract_cnt;
    logic [INTERVAL_W-1:0] ms_cnt;
    logic                  first_beat;
    logic                  beat_now;
    logic                  ns_entry;

    logic [INTERVAL_W-1:0] hist [HIST_DEPTH];
    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      sum_next;
    logic [2:0]            fill;
    logic [2:0]            fill_next;
    rate_class_t           rate_q;

    ms_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign rate_class = rate_q;

    // Beat qualification and no-signal entry; a beat masks a coincident tick.
    always_comb begin
        beat_now = (state == ARMED) && sample_valid && (ecg_sample >= HI_C);
        ns_entry = !beat_now && tick && (ms_cnt == MAX_M1_C);
    end

    // Running-sum and fill values for the next history push.
    always_comb begin
        sum_next  = sum + {2'b00, interval_ms} - {2'b00, hist[HIST_DEPTH-1]};
        fill_next = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    end

    // Peak FSM with refractory counter; beat is its registered output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ARMED;
            refract_cnt <= '0;
            beat        <= 1'b0;
        end else begin
            beat <= beat_now;
            unique case (state)
                ARMED:   if (beat_now) state <= PEAK;
                PEAK:    if (sample_valid && (ecg_sample < LO_C)) state <= REFRACT;
                REFRACT: if (refract_cnt == '0) state <= ARMED;
                default: state <= ARMED;
            endcase
            if (beat_now) begin
                refract_cnt <= REFRACT_C;
            end else if (tick && (refract_cnt != '0)) begin
                refract_cnt <= refract_cnt - 1'b1;
            end
        end
    end

    // Interval timer, first-beat tracking and no-signal level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_cnt         <= '0;
            first_beat     <= 1'b1;
            no_signal      <= 1'b0;
            interval_valid <= 1'b0;
            interval_ms    <= '0;
        end else begin
            interval_valid <= beat_now && !first_beat;
            if (beat_now && !first_beat) begin
                interval_ms <= ms_cnt;
            end
            if (beat_now) begin
                ms_cnt     <= '0;
                first_beat <= 1'b0;
                no_signal  <= 1'b0;
            end else if (tick && (ms_cnt != MAX_C)) begin
                ms_cnt <= ms_cnt + 1'b1;
                if (ns_entry) begin
                    no_signal  <= 1'b1;
                    first_beat <= 1'b1;
                end
            end
        end
    end

    // History shift, running average and rate class, one clock after each interval.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= '0;
            end
            sum          <= '0;
            fill         <= '0;
            avg_interval <= '0;
            rate_q       <= NONE;
        end else if (ns_entry) begin
            for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= '0;
            end
            sum          <= '0;
            fill         <= '0;
            avg_interval <= '0;
            rate_q       <= NONE;
        end else if (interval_valid) begin
            hist[0] <= interval_ms;
            for (int unsigned i = 1; i < HIST_DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
            sum  <= sum_next;
            fill <= fill_next;
            if (fill_next == 3'd4) begin
                avg_interval <= sum_next[SUM_W-1:2];
                rate_q       <= classify_rate(sum_next[SUM_W-1:2], SLOW_C, FAST_C);
            end else begin
                avg_interval <= '0;
                rate_q       <= NONE;
            end
        end
    end

endmodule

// File: tb/tb_ecg_beat_detector.sv
// Randomized self-checking bench for ecg_beat_detector with a queue-based
// behavioural model and literal expectations for the directed scenarios.
module tb_ecg_beat_detector;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        sv;
    logic [7:0]  smp;
    logic        beat;
    logic        interval_valid;
    logic [11:0] interval_ms;
    logic [11:0] avg_interval;
    logic        no_signal;
    logic [1:0]  rate_class;

    int n_checks = 0;
    int n_err    = 0;
    int beat_cnt = 0;
    int last_fire = 0;

    logic        f_beat, f_iv, f_ns;
    logic [11:0] f_int, f_avg;
    logic [1:0]  f_rc;

    // model state
    int   m_e = 0, m_ms = 0, m_ref = 0, m_int = 0, m_avg = 0, m_rc = 0;
    bit   m_first = 1, m_peak = 0, m_refr = 0;
    logic m_beat = 0, m_iv = 0, m_ns = 0;
    int   hist_q[$];

    ecg_beat_detector #(
        .TICK_DIV    (TD),
        .THRESH_HI   (200),
        .THRESH_LO   (160),
        .REFRACT_MS  (250),
        .MAX_INTERVAL(2000),
        .SLOW_MS     (1000),
        .FAST_MS     (500)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sv),
        .ecg_sample    (smp),
        .beat          (beat),
        .interval_valid(interval_valid),
        .interval_ms   (interval_ms),
        .avg_interval  (avg_interval),
        .no_signal     (no_signal),
        .rate_class    (rate_class)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input int avg);
        if (avg > 1000) return 1;
        if (avg < 500) return 3;
        return 2;
    endfunction

    task automatic model_init();
        m_e = 0; m_ms = 0; m_ref = 0; m_int = 0; m_avg = 0; m_rc = 0;
        m_first = 1; m_peak = 0; m_refr = 0;
        m_beat = 0; m_iv = 0; m_ns = 0;
        hist_q.delete();
    endtask

    // One clock of the specified behaviour, written in terms of ms elapsed and a history list.
    task automatic model_step(input logic v, input logic [7:0] s);
        bit tk, fire, prev_iv;
        int prev_int, total;
        m_e++;
        tk       = (m_e > 1) && (((m_e - 1) % TD) == 0);
        fire     = v && (s >= 200) && !m_peak && !m_refr;
        prev_iv  = m_iv;
        prev_int = m_int;
        m_beat   = fire;
        m_iv     = fire && !m_first;
        if (m_iv) m_int = m_ms;
        if (prev_iv) begin
            hist_q.push_back(prev_int);
            if (hist_q.size() > 4) hist_q = hist_q[1:$];
            if (hist_q.size() == 4) begin
                total = 0;
                foreach (hist_q[i]) total += hist_q[i];
                m_avg = total / 4;
                m_rc  = classify(m_avg);
            end else begin
                m_avg = 0;
                m_rc  = 0;
            end
        end
        if (fire) begin
            m_ms = 0; m_first = 0; m_ns = 0;
        end else if (tk && m_ms < 2000) begin
            m_ms++;
            if (m_ms == 2000) begin
                m_ns = 1; m_first = 1; m_avg = 0; m_rc = 0;
                hist_q.delete();
            end
        end
        if (!m_peak && !m_refr) begin
            if (fire) m_peak = 1;
        end else if (m_peak) begin
            if (v && s < 160) begin m_peak = 0; m_refr = 1; end
        end else if (m_ref == 0) begin
            m_refr = 0;
        end
        if (fire) m_ref = 250;
        else if (tk && m_ref > 0) m_ref--;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_init();
        else model_step(sv, smp);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        #2;
        if (beat === 1'b1) beat_cnt++;
        chk("beat",           32'(beat),           32'(m_beat));
        chk("interval_valid", 32'(interval_valid), 32'(m_iv));
        chk("interval_ms",    32'(interval_ms),    32'(m_int));
        chk("avg_interval",   32'(avg_interval),   32'(m_avg));
        chk("no_signal",      32'(no_signal),      32'(m_ns));
        chk("rate_class",     32'(rate_class),     32'(m_rc));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_drive();
        if (($urandom % 8) == 0) begin
            sv = 1'b0; smp = 8'd255;
        end else begin
            sv = 1'($urandom % 2); smp = 8'($urandom_range(0, 159));
        end
    endtask

    task automatic idle_for(input int n);
        repeat (n) begin idle_drive(); step(); end
    endtask

    task automatic do_reset();
        reset = 1'b0; sv = 1'b0; smp = '0;
        repeat (3) step();
        reset = 1'b1;
    endtask

    function automatic int next_phase(input int min_e, input int ph);
        int e = min_e;
        while (((e - 1) % TD) != ph) e++;
        return e;
    endfunction

    // Drive a clean peak so that the threshold crossing lands on edge E.
    task automatic fire_at(input int E);
        if (m_e >= E) begin
            n_checks++; n_err++;
            $display("FAIL schedule: edge %0d already passed (now %0d)", E, m_e);
        end
        while (m_e < E - 1) begin idle_drive(); step(); end
        sv = 1'b1; smp = 8'd220; step();
        f_beat = beat; f_iv = interval_valid; f_int = interval_ms; f_ns = no_signal;
        sv = 1'b1; smp = 8'd100; step();
        f_avg = avg_interval; f_rc = rate_class;
        idle_drive();
        last_fire = E;
    endtask

    task automatic rand_peak_at(input int E);
        while (m_e < E - 1) begin idle_drive(); step(); end
        sv = 1'b1; smp = 8'($urandom_range(200, 255)); step();
        repeat ($urandom_range(0, 4)) begin
            sv = 1'($urandom % 2); smp = 8'($urandom_range(160, 255)); step();
        end
        sv = 1'b1; smp = 8'($urandom_range(0, 159)); step();
        last_fire = E;
    endtask

    initial begin
        int bc0;
        int gap;
        reset = 1'b0; sv = 1'b0; smp = '0;
        repeat (3) step();
        chk("rst_outputs", 32'({beat, interval_valid, interval_ms, avg_interval, no_signal, rate_class}), 32'd0);
        reset = 1'b1;
        idle_for(10);

        // 1: reset mid-pulse clears outputs at once, then FSM is armed again
        sv = 1'b1; smp = 8'd220; step();
        chk("t1_beat_before_rst", 32'(beat), 32'd1);
        reset = 1'b0; #1;
        chk("t1_rst_beat", 32'(beat), 32'd0);
        chk("t1_rst_rest", 32'({interval_valid, interval_ms, avg_interval, no_signal, rate_class}), 32'd0);
        sv = 1'b0; step(); step();
        reset = 1'b1; step();
        chk("t1_rate_after", 32'(rate_class), 32'd0);
        sv = 1'b1; smp = 8'd220; step();
        chk("t1_armed_beat", 32'(beat), 32'd1);
        chk("t1_armed_noiv", 32'(interval_valid), 32'd0);
        sv = 1'b1; smp = 8'd100; step();
        idle_for(4);

        // 2: two peaks 800 ms apart
        do_reset();
        fire_at(next_phase(m_e + 2, 1));
        chk("t2_beat1", 32'(f_beat), 32'd1);
        chk("t2_noiv1", 32'(f_iv), 32'd0);
        fire_at(last_fire + 800 * TD);
        chk("t2_beat2", 32'(f_beat), 32'd1);
        chk("t2_iv2", 32'(f_iv), 32'd1);
        chk("t2_int800", 32'(f_int), 32'd800);

        // 3: bounce gives one beat; re-peak inside refractory window gives none
        do_reset();
        idle_for(3);
        bc0 = beat_cnt;
        sv = 1'b1; smp = 8'd220; step();
        last_fire = m_e;
        smp = 8'd180; step();
        smp = 8'd220; step();
        smp = 8'd100; step();
        idle_for(3);
        chk("t3_one_beat", 32'(beat_cnt - bc0), 32'd1);
        fire_at(last_fire + 100 * TD);
        idle_for(3);
        chk("t3_refract_nobeat", 32'(f_beat), 32'd0);
        chk("t3_count_still1", 32'(beat_cnt - bc0), 32'd1);

        // 4: 400 ms spacing -> FAST, then 1200 ms spacing -> SLOW
        do_reset();
        fire_at(next_phase(m_e + 2, 1));
        for (int i = 1; i <= 4; i++) begin
            fire_at(last_fire + 400 * TD);
            if (i == 3) begin
                chk("t4_avg_fill3", 32'(f_avg), 32'd0);
                chk("t4_rate_fill3", 32'(f_rc), 32'd0);
            end
        end
        chk("t4_int400", 32'(f_int), 32'd400);
        chk("t4_avg400", 32'(f_avg), 32'd400);
        chk("t4_fast", 32'(f_rc), 32'd3);
        for (int i = 1; i <= 4; i++) fire_at(last_fire + 1200 * TD);
        chk("t4_avg1200", 32'(f_avg), 32'd1200);
        chk("t4_slow", 32'(f_rc), 32'd1);

        // 5: 2000 ms without a beat -> no_signal; next beat clears it without interval
        while (m_e < last_fire + 2000 * TD + 8) begin idle_drive(); step(); end
        chk("t5_nosig", 32'(no_signal), 32'd1);
        chk("t5_avg0", 32'(avg_interval), 32'd0);
        chk("t5_rate0", 32'(rate_class), 32'd0);
        fire_at(next_phase(m_e + 2, 1));
        chk("t5_beat", 32'(f_beat), 32'd1);
        chk("t5_noiv", 32'(f_iv), 32'd0);
        chk("t5_nosig_clr", 32'(f_ns), 32'd0);

        // 6: crossing on a tick edge drops that tick; invalid samples never fire
        fire_at(last_fire + 800 * TD - 1);
        chk("t6_iv", 32'(f_iv), 32'd1);
        chk("t6_int799", 32'(f_int), 32'd799);
        idle_for(300 * TD);
        bc0 = beat_cnt;
        sv = 1'b0; smp = 8'd255;
        repeat (20) step();
        chk("t6_invalid_nobeat", 32'(beat_cnt - bc0), 32'd0);

        // random peaks, bounces, phases and occasional signal loss
        do_reset();
        last_fire = m_e + 4;
        for (int i = 0; i < 8; i++) begin
            gap = (($urandom % 6) == 0) ? 2100 : int'($urandom_range(50, 700));
            rand_peak_at(last_fire + gap * TD + int'($urandom_range(0, 3)));
        end
        idle_for(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        n_checks++; n_err++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
